// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm match detection, ring/snooze sequencing and gated buzzer tone
module alarm_sequencer #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_DIV       = 50_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic [3:0] hr_10s,
  input  logic [3:0] hr_1s,
  input  logic [3:0] min_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] hr_10sa,
  input  logic [3:0] hr_1sa,
  input  logic [3:0] min_10sa,
  input  logic [3:0] min_1sa,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic [2:0] state
);

  localparam int RW = (RING_SECONDS   > 1) ? $clog2(RING_SECONDS)   : 1;
  localparam int SW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
  localparam int TW = (TONE_DIV       > 1) ? $clog2(TONE_DIV)       : 1;

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECONDS - 1);
  localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);
  localparam logic [1:0]    MAX_CNT     = 2'(MAX_SNOOZE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_RINGING = 3'd2,
    S_SNOOZE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        st_q, st_d;
  logic [RW-1:0] ring_sec_q, ring_sec_d;
  logic [SW-1:0] snz_sec_q, snz_sec_d;
  logic [TW-1:0] tone_ctr_q, tone_ctr_d;
  logic          tone_q, tone_d;
  logic          beep_q, beep_d;
  logic [1:0]    snooze_cnt_q, snooze_cnt_d;
  logic          match, match_q, trigger, enter_ring, buzzer_d;

  assign match   = ({hr_10s, hr_1s, min_10s, min_1s} == {hr_10sa, hr_1sa, min_10sa, min_1sa});
  assign trigger = match & ~match_q;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= S_IDLE;
      ring_sec_q   <= '0;
      snz_sec_q    <= '0;
      tone_ctr_q   <= '0;
      tone_q       <= 1'b0;
      beep_q       <= 1'b0;
      snooze_cnt_q <= 2'd0;
      match_q      <= 1'b0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      st_q         <= st_d;
      ring_sec_q   <= ring_sec_d;
      snz_sec_q    <= snz_sec_d;
      tone_ctr_q   <= tone_ctr_d;
      tone_q       <= tone_d;
      beep_q       <= beep_d;
      snooze_cnt_q <= snooze_cnt_d;
      match_q      <= match;
      buzzer       <= buzzer_d;
      ringing      <= (st_d == S_RINGING);
      snoozing     <= (st_d == S_SNOOZE);
    end
  end

  always_comb begin
    st_d         = st_q;
    ring_sec_d   = ring_sec_q;
    snz_sec_d    = snz_sec_q;
    tone_ctr_d   = tone_ctr_q;
    tone_d       = tone_q;
    beep_d       = beep_q;
    snooze_cnt_d = snooze_cnt_q;
    enter_ring   = 1'b0;

    if (st_q == S_RINGING) begin
      if (tone_ctr_q == TONE_LAST) begin
        tone_ctr_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_ctr_d = tone_ctr_q + TW'(1);
      end
    end

    if (!alarm_en) begin
      st_d         = S_IDLE;
      ring_sec_d   = '0;
      snz_sec_d    = '0;
      tone_ctr_d   = '0;
      tone_d       = 1'b0;
      beep_d       = 1'b0;
      snooze_cnt_d = 2'd0;
    end else begin
      case (st_q)
        S_IDLE: st_d = S_ARMED;
        S_ARMED: begin
          if (trigger) begin
            st_d         = S_RINGING;
            enter_ring   = 1'b1;
            snooze_cnt_d = 2'd0;
          end
        end
        S_RINGING: begin
          // Buttons outrank the tick; an exhausted snooze falls through to tick handling.
          if (stop_btn) begin
            st_d = S_DONE;
          end else if (snooze_btn && (snooze_cnt_q < MAX_CNT)) begin
            st_d         = S_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
            snz_sec_d    = '0;
          end else if (tick_1hz) begin
            if (ring_sec_q == RING_LAST) begin
              st_d = S_DONE;
            end else begin
              ring_sec_d = ring_sec_q + RW'(1);
              beep_d     = ~beep_q;
            end
          end
        end
        S_SNOOZE: begin
          if (stop_btn) begin
            st_d = S_DONE;
          end else if (tick_1hz) begin
            if (snz_sec_q == SNOOZE_LAST) begin
              st_d       = S_RINGING;
              enter_ring = 1'b1;
            end else begin
              snz_sec_d = snz_sec_q + SW'(1);
            end
          end
        end
        S_DONE: begin
          // Wait out the matching minute so a stopped alarm cannot re-ring it.
          snooze_cnt_d = 2'd0;
          if (!match) st_d = S_ARMED;
        end
        default: st_d = S_IDLE;
      endcase
    end

    if (enter_ring) begin
      ring_sec_d = '0;
      tone_ctr_d = '0;
      tone_d     = 1'b0;
      beep_d     = 1'b1;
    end

    buzzer_d = tone_q & beep_q & (st_q == S_RINGING) & (st_d == S_RINGING);
  end

  assign snooze_cnt = snooze_cnt_q;
  assign state      = st_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - randomized scoreboard bench for alarm_sequencer
module tb_alarm_sequencer;

  localparam int RING = 4;
  localparam int SNZ  = 3;
  localparam int MAXS = 2;
  localparam int TDIV = 4;
  localparam logic [15:0] ALARM = 16'h0730;

  logic       clk_100MHz = 1'b0;
  logic       reset_n    = 1'b0;
  logic       tick_1hz   = 1'b0;
  logic       alarm_en   = 1'b0;
  logic [3:0] hr_10s = 4'd0, hr_1s = 4'd0, min_10s = 4'd0, min_1s = 4'd0;
  logic [3:0] hr_10sa, hr_1sa, min_10sa, min_1sa;
  logic       snooze_btn = 1'b0;
  logic       stop_btn   = 1'b0;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_cnt;
  logic [2:0] state;

  assign {hr_10sa, hr_1sa, min_10sa, min_1sa} = ALARM;

  alarm_sequencer #(
    .RING_SECONDS(RING), .SNOOZE_SECONDS(SNZ), .MAX_SNOOZE(MAXS), .TONE_DIV(TDIV)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .tick_1hz(tick_1hz), .alarm_en(alarm_en),
    .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
    .hr_10sa(hr_10sa), .hr_1sa(hr_1sa), .min_10sa(min_10sa), .min_1sa(min_1sa),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_cnt(snooze_cnt), .state(state)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [2:0] st;
    logic       ring;
    logic       snz;
    logic [1:0] cnt;
    logic       buz;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0..4, ticks counted in the ring/snooze windows,
  // snoozes used, cycles spent ringing since entry (drives the tone phase).
  int m_mode = 0, m_ringt = 0, m_snzt = 0, m_used = 0, m_k = 0;
  bit m_mprev = 0, m_buz = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ringt = 0; m_snzt = 0; m_used = 0; m_k = 0; m_mprev = 0; m_buz = 0;
  endtask

  task automatic model_step(input bit en, input bit tick, input bit stop, input bit snz, input bit mt);
    bit trig, old_ring, old_tone, old_beep;
    trig     = mt && !m_mprev;
    m_mprev  = mt;
    old_ring = (m_mode == 2);
    old_tone = ((m_k / TDIV) % 2) == 1;
    old_beep = (m_ringt % 2) == 0;
    if (!en) begin
      m_mode = 0; m_ringt = 0; m_snzt = 0; m_used = 0; m_k = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (trig) begin m_mode = 2; m_ringt = 0; m_k = 0; m_used = 0; end
        2: begin
          if (stop) m_mode = 4;
          else if (snz && m_used < MAXS) begin m_mode = 3; m_used++; m_snzt = 0; end
          else if (tick) begin
            if (m_ringt == RING - 1) m_mode = 4;
            else m_ringt++;
          end
          if (m_mode == 2) m_k++;
        end
        3: begin
          if (stop) m_mode = 4;
          else if (tick) begin
            if (m_snzt == SNZ - 1) begin m_mode = 2; m_ringt = 0; m_k = 0; end
            else m_snzt++;
          end
        end
        default: begin
          m_used = 0;
          if (!mt) m_mode = 1;
        end
      endcase
    end
    m_buz = old_tone && old_beep && old_ring && (m_mode == 2);
  endtask

  task automatic apply(input bit en, input bit tick, input bit stop, input bit snz, input logic [15:0] t);
    exp_t e;
    alarm_en = en; tick_1hz = tick; stop_btn = stop; snooze_btn = snz;
    {hr_10s, hr_1s, min_10s, min_1s} = t;
    model_step(en, tick, stop, snz, t == ALARM);
    e.st = 3'(m_mode); e.ring = (m_mode == 2); e.snz = (m_mode == 3);
    e.cnt = 2'(m_used); e.buz = m_buz;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit en, input bit tick, input bit stop, input bit snz, input logic [15:0] t);
    @(negedge clk_100MHz);
    apply(en, tick, stop, snz, t);
  endtask

  task automatic idle(input int n, input logic [15:0] t);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, t);
  endtask

  task automatic ticks(input int n, input logic [15:0] t);
    for (int i = 0; i < n; i++) begin
      step(1, 1, 0, 0, t);
      idle(2, t);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 16'(state), 16'(e.st));
        chk("ringing", 16'(ringing), 16'(e.ring));
        chk("snoozing", 16'(snoozing), 16'(e.snz));
        chk("snooze_cnt", 16'(snooze_cnt), 16'(e.cnt));
        chk("buzzer", 16'(buzzer), 16'(e.buz));
      end
    end
  end

  initial begin : stimulus
    logic [15:0] t;
    int r;
    repeat (3) @(posedge clk_100MHz);
    #2;
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_buzzer", 16'(buzzer), 16'd0);
    chk("reset_ringing", 16'(ringing), 16'd0);
    chk("reset_snoozing", 16'(snoozing), 16'd0);
    chk("reset_snooze_cnt", 16'(snooze_cnt), 16'd0);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    model_reset();
    apply(0, 0, 0, 0, 16'h0729);

    // basic ring, tone, timeout, re-arm on minute change
    idle(3, 16'h0729);
    idle(14, ALARM);
    ticks(RING, ALARM);
    idle(2, 16'h0731);

    // snooze twice, third snooze ignored, timeout
    idle(2, 16'h0729);
    idle(3, ALARM);
    step(1, 0, 0, 1, ALARM);
    ticks(SNZ, ALARM);
    step(1, 0, 0, 1, ALARM);
    ticks(SNZ, ALARM);
    step(1, 0, 0, 1, ALARM);
    idle(2, ALARM);
    ticks(RING, ALARM);
    idle(2, 16'h0731);

    // stop and snooze together while ringing
    idle(2, 16'h0729);
    idle(2, ALARM);
    step(1, 0, 0, 1, ALARM);
    ticks(SNZ, ALARM);
    step(1, 0, 1, 1, ALARM);
    idle(2, 16'h0729);

    // disable during snooze, re-enable while time matches
    idle(2, ALARM);
    step(1, 0, 0, 1, ALARM);
    step(0, 0, 0, 0, ALARM);
    idle(8, ALARM);

    // stop during matching minute, held for 100 ticks
    idle(2, 16'h0729);
    idle(2, ALARM);
    step(1, 0, 1, 0, ALARM);
    for (int i = 0; i < 100; i++) step(1, 1, 0, 0, ALARM);
    idle(2, 16'h0731);

    // randomized traffic
    t = 16'h0729;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) t = 16'h0729;
      else if (r < 8) t = ALARM;
      else if (r < 10) t = 16'h0731;
      else if (r < 11) t = 16'(($urandom_range(0, 2) << 12) | ($urandom_range(0, 9) << 8) | $urandom_range(0, 89));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 14) == 0), t);
    end

    // asynchronous reset while the buzzer is sounding
    idle(2, 16'h0729);
    idle(2, ALARM);
    idle(5, ALARM);
    @(posedge clk_100MHz);
    #2;
    chk("pre_reset_buzzer", 16'(buzzer), 16'd1);
    reset_n = 1'b0;
    #1;
    chk("async_buzzer", 16'(buzzer), 16'd0);
    chk("async_ringing", 16'(ringing), 16'd0);
    chk("async_state", 16'(state), 16'd0);
    model_reset();
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    apply(1, 0, 0, 0, ALARM);
    idle(10, ALARM);

    @(posedge clk_100MHz);
    #3;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequences the alarm function of the digital clock. It compares the running time against the stored alarm time and drives a gated buzzer tone for a bounded ring window. It also handles snooze and stop requests and re-arms once the matching minute has passed. It sits between the timekeeping counters, the alarm-setting registers and the buzzer pin, and runs in the 100 MHz domain.

## Interface
- RING_SECONDS, 60: ring window length in 1 Hz ticks before auto-stop.
- SNOOZE_SECONDS, 300: snooze interval in 1 Hz ticks.
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..3).
- TONE_DIV, 50_000: clk cycles per buzzer half-period (1 kHz at 100 MHz).
- clk_100MHz  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse once per second, synchronous to clk_100MHz.
- alarm_en  in  1  alarm switch (level, already synchronised).
- hr_10s, hr_1s, min_10s, min_1s  in  4 each  current time, BCD.
- hr_10sa, hr_1sa, min_10sa, min_1sa  in  4 each  alarm time, BCD.
- snooze_btn, stop_btn  in  1 each  debounced one-cycle press pulses.
- buzzer  out  1  gated tone to the piezo.
- ringing  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- snooze_cnt  out  2  snoozes used in the current event.
- state  out  3  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3, DONE=4.

## Operation
- match = full 16-bit equality of current time and alarm time.
- match_q is a register; match_q <= match every cycle.
- trigger = match & ~match_q (rising edge only).
- Enabling the alarm while the times already match does not ring.
- Priority in every state: alarm_en=0 > stop_btn > snooze_btn > timers.
- alarm_en=0 in any state: go to IDLE and clear all counters, snooze_cnt and tone.
- IDLE: alarm_en=1 -> ARMED.
- ARMED: trigger -> RINGING.
  - On entry: ring_sec=0, tone_ctr=0, tone=0, beep_phase=1, snooze_cnt=0.
- RINGING:
  - stop_btn -> DONE.
  - snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, snz_sec=0.
  - snooze_btn with snooze_cnt==MAX_SNOOZE is ignored.
  - tick_1hz with ring_sec==RING_SECONDS-1 -> DONE.
  - Otherwise tick_1hz increments ring_sec and toggles beep_phase.
- SNOOZE:
  - stop_btn -> DONE.
  - tick_1hz with snz_sec==SNOOZE_SECONDS-1 -> RINGING, with the RINGING entry values except snooze_cnt, which is kept.
  - Otherwise tick_1hz increments snz_sec.
- DONE: snooze_cnt cleared; match==0 -> ARMED.
  - A stop or timeout during the matching minute therefore never re-rings that minute.
- Tone:
  - tone_ctr counts 0..TONE_DIV-1 only in RINGING; tone toggles at wrap.
  - buzzer = tone & beep_phase & ringing, registered.
- Counters saturate only via state exit; no wrap-around inside a state.
- Widths: counters are clog2(param) bits, minimum 1; snooze_cnt is 2 bits.

## Timing
- After reset: state=IDLE, buzzer=0, ringing=0, snoozing=0, snooze_cnt=0, match_q=0.
- Every output is registered.
- The cycle in which match first rises (state ARMED) is edge N; state=RINGING and ringing=1 after edge N+1.
- The first buzzer high occurs TONE_DIV cycles after RINGING entry, plus one register stage.
- Button-driven state changes take effect at the next edge after the pulse cycle.
- Ring window covers exactly RING_SECONDS tick_1hz pulses after entry.
- Snooze covers exactly SNOOZE_SECONDS tick_1hz pulses.
- stop_btn and snooze_btn in the same cycle: stop wins, snooze_cnt unchanged.
- tick_1hz coinciding with a button in the same cycle: the button transition wins and the tick is not counted.
- reset_n low mid-ring: buzzer drops asynchronously.
- After reset_n release: ARMED one cycle later if alarm_en=1. A still-present match then does not ring, because match_q is loaded first.

## Test plan
Bench parameters: RING_SECONDS=4, SNOOZE_SECONDS=3, MAX_SNOOZE=2, TONE_DIV=4.
- Basic ring: alarm 07:30, time steps 07:29 -> 07:30 with alarm_en=1 -> ringing=1 one edge later, state=2. Buzzer toggles every 4 cycles while beep_phase=1. After 4 ticks: state=4, buzzer=0. Time 07:31 -> state=1.
- Snooze: ring, pulse snooze_btn -> state=3, snooze_cnt=1, snoozing=1. After 3 ticks -> state=2. Second snooze -> snooze_cnt=2. A third snooze_btn is ignored (state stays 2). Timeout -> DONE, snooze_cnt=0.
- Stop priority: stop_btn and snooze_btn in the same cycle while ringing -> state=4, snooze_cnt unchanged.
- Disable override: alarm_en->0 during SNOOZE -> state=0 next edge, all outputs 0, snooze_cnt=0. Re-enable while time==alarm -> state=1 and no ring.
- No re-ring: stop during 07:30 with time held at 07:30 for 100 ticks -> state stays 4, buzzer 0.
- Async reset: reset_n low mid-ring, with no clock edge -> buzzer=0 and ringing=0 immediately. After release with alarm_en=1 and match held -> state=1, no ring.
